// File: rtl/booth_arith_pkg.sv
// booth_arith_pkg
// Shared definitions for the Booth multiplier / sequential divider pair:
//   - div_state_e  : divider FSM states
//   - div_latency  : clocks from an accepted start to the done pulse
//   - twos_negate  : two's-complement negate (ARITH_MAX_W bits)
//   - abs_val      : magnitude given a value and its sign bit
// Callers zero-extend narrower operands to ARITH_MAX_W and truncate the
// result back with a size cast. Only the low bits of a negate matter, so
// zero extension gives the same answer as sign extension.
package booth_arith_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_e;

   localparam int ARITH_MAX_W = 32;

   function automatic int div_latency(input int width);
      return width + 2;
   endfunction

   function automatic logic [ARITH_MAX_W-1:0] twos_negate(input logic [ARITH_MAX_W-1:0] v);
      return (~v) + ARITH_MAX_W'(1);
   endfunction

   function automatic logic [ARITH_MAX_W-1:0] abs_val(input logic [ARITH_MAX_W-1:0] v,
                                                      input logic                   neg);
      return neg ? twos_negate(v) : v;
   endfunction

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix
// Combinational sign restoration for the sequential divider.
// Ports:
//   qmag, rmag : unsigned quotient / remainder magnitudes from the iteration
//   a_val      : original dividend (two's complement)
//   b_val      : original divisor (two's complement)
//   q, r       : signed quotient (truncated toward zero) and remainder
//                (the remainder takes the sign of the dividend)
//   ovf        : most-negative / -1 overflow
module div_sign_fix #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] qmag,
   input  logic [WIDTH-1:0] rmag,
   input  logic [WIDTH-1:0] a_val,
   input  logic [WIDTH-1:0] b_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             ovf
);
   import booth_arith_pkg::*;

   logic [WIDTH-1:0] most_neg;

   assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};

   always_comb begin
      ovf = (a_val == most_neg) && (b_val == {WIDTH{1'b1}});
      q   = (a_val[WIDTH-1] ^ b_val[WIDTH-1]) ? WIDTH'(twos_negate(ARITH_MAX_W'(qmag))) : qmag;
      r   = a_val[WIDTH-1] ? WIDTH'(twos_negate(ARITH_MAX_W'(rmag))) : rmag;
      // The true quotient +2^(WIDTH-1) does not fit; it wraps to the most
      // negative value and the remainder is exactly zero.
      if (ovf) begin
         q = most_neg;
         r = '0;
      end
   end

endmodule

// File: rtl/seq_booth_divider.sv
// seq_booth_divider
// Sequential signed restoring divider, one quotient bit per clock.
// States IDLE -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, sampled only in IDLE
//   a, b        : signed dividend / divisor, captured on accepted start
//   busy        : high while an operation is in flight (through DONE)
//   done        : one-cycle pulse; q/r/ovf/dbz valid from this cycle
//   q, r        : signed quotient / remainder, held until the next start
//   ovf         : most-negative / -1 overflow
//   dbz         : divide-by-zero flag
// Optional feature macro SEQ_DIV_DBZ_EN: when defined, b == 0 is caught at
// acceptance and the FSM jumps straight to DONE with dbz=1, q=all ones,
// r=a. When undefined, dbz is tied low and b == 0 runs at full latency.
module seq_booth_divider #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             ovf,
   output logic             dbz
);
   import booth_arith_pkg::*;

   localparam int CNT_W = $clog2(WIDTH);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] bmag_q, bmag_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             ovf_q, ovf_d;
`ifdef SEQ_DIV_DBZ_EN
   logic             dbz_q, dbz_d;
`endif

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] fix_q;
   logic [WIDTH-1:0] fix_r;
   logic             fix_ovf;

   // dvd_q starts as |a| and, as its bits shift out into the accumulator,
   // fills up with quotient bits from the right, so it ends holding |q|.
   assign shifted = {acc_q, dvd_q[WIDTH-1]};
   assign trial   = shifted - {2'b00, bmag_q};

   div_sign_fix #(
      .WIDTH (WIDTH)
   ) u_sign_fix (
      .qmag  (dvd_q),
      .rmag  (acc_q[WIDTH-1:0]),
      .a_val (a_q),
      .b_val (b_q),
      .q     (fix_q),
      .r     (fix_r),
      .ovf   (fix_ovf)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvd_d   = dvd_q;
      bmag_d  = bmag_q;
      a_d     = a_q;
      b_d     = b_q;
      q_d     = q_q;
      r_d     = r_q;
      ovf_d   = ovf_q;
`ifdef SEQ_DIV_DBZ_EN
      dbz_d   = dbz_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               dvd_d   = WIDTH'(abs_val(ARITH_MAX_W'(a), a[WIDTH-1]));
               bmag_d  = WIDTH'(abs_val(ARITH_MAX_W'(b), b[WIDTH-1]));
               cnt_d   = '0;
               acc_d   = '0;
               q_d     = '0;
               r_d     = '0;
               ovf_d   = 1'b0;
               state_d = CALC;
`ifdef SEQ_DIV_DBZ_EN
               dbz_d   = 1'b0;
               if (b == '0) begin
                  dbz_d   = 1'b1;
                  q_d     = '1;
                  r_d     = a;
                  state_d = DONE;
               end
`endif
            end
         end
         CALC: begin
            // A clear top bit on the trial difference means the divisor fit.
            if (!trial[WIDTH+1]) begin
               acc_d = trial[WIDTH:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = shifted[WIDTH:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            q_d     = fix_q;
            r_d     = fix_r;
            ovf_d   = fix_ovf;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         dvd_q   <= '0;
         bmag_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         ovf_q   <= 1'b0;
`ifdef SEQ_DIV_DBZ_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvd_q   <= dvd_d;
         bmag_q  <= bmag_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         r_q     <= r_d;
         ovf_q   <= ovf_d;
`ifdef SEQ_DIV_DBZ_EN
         dbz_q   <= dbz_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign q    = q_q;
   assign r    = r_q;
   assign ovf  = ovf_q;
`ifdef SEQ_DIV_DBZ_EN
   assign dbz  = dbz_q;
`else
   assign dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_booth_divider.sv
// tb_seq_booth_divider
// Directed-vector bench for seq_booth_divider at WIDTH=5. Latency counts
// clock edges from the edge that samples start (counted as 1) to the edge
// after which done is seen high.
module tb_seq_booth_divider;

   localparam int WIDTH    = 5;
   localparam int FULL_LAT = 7;
   localparam int MAX_WAIT = 40;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             ovf;
   logic             dbz;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_booth_divider #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .r     (r),
      .ovf   (ovf),
      .dbz   (dbz)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one request, let the acceptance edge pass, then wait for done.
   task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] ta,
                                input logic [WIDTH-1:0] tb, output int lat);
      @(negedge clk);
      a     = ta;
      b     = tb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
      if (tb != '0) begin
         checkOutput({tag, " q cleared"}, 32'(q), 32'd0);
      end
      while (!done && lat < MAX_WAIT) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic runOp(input string tag, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb, input int exp_lat,
                        input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                        input logic exp_ovf, input logic exp_dbz);
      int lat;
      applyStimulus(tag, ta, tb, lat);
      checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, " done"}, 32'(done), 32'd1);
      checkOutput({tag, " q"}, 32'(q), 32'(exp_q));
      checkOutput({tag, " r"}, 32'(r), 32'(exp_r));
      checkOutput({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
      checkOutput({tag, " dbz"}, 32'(dbz), 32'(exp_dbz));
      @(posedge clk);
      #1;
      checkOutput({tag, " done pulse end"}, 32'(done), 32'd0);
      checkOutput({tag, " busy end"}, 32'(busy), 32'd0);
      checkOutput({tag, " q hold"}, 32'(q), 32'(exp_q));
   endtask

   initial begin
      int lat;
      int seen;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset q", 32'(q), 32'd0);
      checkOutput("reset r", 32'(r), 32'd0);
      checkOutput("reset ovf", 32'(ovf), 32'd0);
      checkOutput("reset dbz", 32'(dbz), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Signed quadrants of 13 / 4; each op starts in the cycle after the
      // previous done, so these are also back-to-back acceptances.
      runOp("13/4",   5'd13,     5'd4,     FULL_LAT, 5'd3,     5'd1,     1'b0, 1'b0);
      runOp("-13/4",  5'(-13),   5'd4,     FULL_LAT, 5'(-3),   5'(-1),   1'b0, 1'b0);
      runOp("13/-4",  5'd13,     5'(-4),   FULL_LAT, 5'(-3),   5'd1,     1'b0, 1'b0);
      runOp("-13/-4", 5'(-13),   5'(-4),   FULL_LAT, 5'd3,     5'(-1),   1'b0, 1'b0);

      // Most-negative boundary: overflow only for the -1 divisor.
      runOp("-16/-1", 5'b10000,  5'b11111, FULL_LAT, 5'b10000, 5'd0,     1'b1, 1'b0);
      runOp("-16/1",  5'b10000,  5'd1,     FULL_LAT, 5'b10000, 5'd0,     1'b0, 1'b0);

      // Divide by zero with a non-negative dividend.
`ifdef SEQ_DIV_DBZ_EN
      runOp("7/0",    5'd7,      5'd0,     1,        5'b11111, 5'd7,     1'b0, 1'b1);
`else
      runOp("7/0",    5'd7,      5'd0,     FULL_LAT, 5'b11111, 5'd7,     1'b0, 1'b0);
`endif

      // start held high for the whole 6/2 operation, with other operands
      // on the bus; only the first request may be taken.
      @(negedge clk);
      a     = 5'd6;
      b     = 5'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      lat = 1;
      while (!done && lat < MAX_WAIT) begin
         a = 5'd9;
         b = 5'd1;
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("spam latency", 32'(lat), 32'(FULL_LAT));
      checkOutput("spam q", 32'(q), 32'd3);
      checkOutput("spam r", 32'(r), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("spam start in DONE ignored", 32'(busy), 32'd0);
      checkOutput("spam q hold", 32'(q), 32'd3);

      // Back-to-back after the held-start run.
      runOp("b2b 9/2", 5'd9, 5'd2, FULL_LAT, 5'd4, 5'd1, 1'b0, 1'b0);

      // Reset in the third CALC cycle kills the operation.
      @(negedge clk);
      a     = 5'd13;
      b     = 5'd4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset done", 32'(done), 32'd0);
      checkOutput("midreset q", 32'(q), 32'd0);
      checkOutput("midreset r", 32'(r), 32'd0);
      checkOutput("midreset ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      checkOutput("midreset no done", 32'(seen), 32'd0);

      runOp("9/3", 5'd9, 5'd3, FULL_LAT, 5'd3, 5'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
